// File: rtl/sample_framer.sv
// Sample framer: buffers a free-running 8-bit sample stream and releases
// fixed-length, gapless frames to the fault detector, one verdict at a time.
module sample_framer #(
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 2048,
  parameter int TIMEOUT    = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  pix_i,
  input  logic        pix_vaild_i,
  input  logic        done_i,
  output logic [7:0]  data_o,
  output logic        start_o,
  output logic        data_vaild_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic        timeout_o,
  output logic [15:0] frame_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(FRAME_LEN);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] FRAME_LEN_C  = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FIFO_DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LAST_SAMP_C  = SW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST_C   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    WAIT_FILL = 2'd0,
    START     = 2'd1,
    STREAM    = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [SW-1:0] samp_cnt_r, samp_cnt_s;
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
  logic [7:0]    data_r;
  logic [15:0]   frame_cnt_r;
  logic          overflow_r, timeout_r;
  logic          rd_en_s, wr_en_s, drop_s, frame_inc_s, timeout_set_s;

  // A full FIFO still accepts a sample when a read frees a slot in the same cycle.
  assign wr_en_s = pix_vaild_i & ((count_r < FIFO_DEPTH_C) | rd_en_s);
  assign drop_s  = pix_vaild_i & ~wr_en_s;

  // Next-state, read-issue and verdict/timeout decisions.
  always_comb begin
    state_s       = state_r;
    rd_en_s       = 1'b0;
    samp_cnt_s    = samp_cnt_r;
    tmo_cnt_s     = tmo_cnt_r;
    frame_inc_s   = 1'b0;
    timeout_set_s = 1'b0;
    case (state_r)
      WAIT_FILL: begin
        if (count_r >= FRAME_LEN_C) begin
          rd_en_s = 1'b1;
          state_s = START;
        end else begin
          state_s = WAIT_FILL;
        end
      end
      START: begin
        rd_en_s    = 1'b1;
        samp_cnt_s = SW'(1);
        state_s    = STREAM;
      end
      STREAM: begin
        if (samp_cnt_r == LAST_SAMP_C) begin
          tmo_cnt_s = TW'(0);
          state_s   = WAIT_DONE;
        end else begin
          rd_en_s    = 1'b1;
          samp_cnt_s = samp_cnt_r + SW'(1);
        end
      end
      WAIT_DONE: begin
        // A verdict arriving on the last timeout cycle still counts as a verdict.
        if (done_i) begin
          frame_inc_s = 1'b1;
          state_s     = WAIT_FILL;
        end else if (tmo_cnt_r == TMO_LAST_C) begin
          frame_inc_s   = 1'b1;
          timeout_set_s = 1'b1;
          state_s       = WAIT_FILL;
        end else begin
          tmo_cnt_s = tmo_cnt_r + TW'(1);
        end
      end
      default: begin
        state_s = WAIT_FILL;
      end
    endcase
  end

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en_s && !rst_i) begin
      mem_r[wr_ptr_r] <= pix_i;
    end
  end

  // State, FIFO bookkeeping, registered read data and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= WAIT_FILL;
      wr_ptr_r    <= AW'(0);
      rd_ptr_r    <= AW'(0);
      count_r     <= CW'(0);
      samp_cnt_r  <= SW'(0);
      tmo_cnt_r   <= TW'(0);
      data_r      <= 8'h00;
      frame_cnt_r <= 16'h0000;
      overflow_r  <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      samp_cnt_r <= samp_cnt_s;
      tmo_cnt_r  <= tmo_cnt_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      // Zero outside frames so data_o is quiet whenever data_vaild_o is low.
      data_r <= rd_en_s ? mem_r[rd_ptr_r] : 8'h00;
      if (frame_inc_s) begin
        frame_cnt_r <= frame_cnt_r + 16'd1;
      end
      if (timeout_set_s) begin
        timeout_r <= 1'b1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign data_o       = data_r;
  assign start_o      = (state_r == START);
  assign data_vaild_o = (state_r == START) || (state_r == STREAM);
  assign busy_o       = (state_r != WAIT_FILL);
  assign overflow_o   = overflow_r;
  assign timeout_o    = timeout_r;
  assign frame_cnt_o  = frame_cnt_r;

endmodule

// File: doc/sample_framer.md
Name: sample_framer

Overview:
- Upstream stage of the magnetic-tile fault detector.
- Accepts a free-running, non-stallable 8-bit sample stream from the sensor/ADC and buffers it in an internal FIFO.
- Emits fixed-length frames to the detector: a one-cycle start pulse, then FRAME_LEN gapless bytes.
- Holds the next frame until the detector reports its verdict (detector valid output fed back as done_i), or until a timeout expires.

Parameters:
- FRAME_LEN, 1024: samples per frame (FFT length); power of two, 4..4096.
- FIFO_DEPTH, 2048: buffer depth in samples; power of two, must be ≥ FRAME_LEN.
- TIMEOUT, 65535: max cycles in WAIT_DONE before abandoning the verdict; ≥ 1.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- pix_i  in  8  incoming sample.
- pix_vaild_i  in  1  pix_i valid this cycle; source cannot stall.
- done_i  in  1  detector verdict-valid pulse.
- data_o  out  8  frame sample to detector.
- start_o  out  1  one-cycle pulse, coincident with sample 0 of a frame.
- data_vaild_o  out  1  data_o carries a frame sample.
- busy_o  out  1  high in START, STREAM or WAIT_DONE.
- overflow_o  out  1  sticky: at least one input sample dropped.
- timeout_o  out  1  sticky: at least one WAIT_DONE timeout.
- frame_cnt_o  out  16  frames completed, whether by done_i or timeout; wraps 0xFFFF→0.

Behaviour:
- Reset: synchronous on rst_i=1; dominates every other event and may occur mid-frame.
  - All outputs go to 0; FIFO is emptied, pointers and count cleared; state becomes WAIT_FILL.
  - Any partial frame is discarded; no start_o may follow reset until a full new frame has been buffered.
- FIFO write:
  - On pix_vaild_i=1, the sample is written if count < FIFO_DEPTH, or if a read occurs in the same cycle.
  - Otherwise the sample is dropped and overflow_o is set; it clears only on reset.
  - Count is updated for simultaneous read and write; there is no off-by-one at the full boundary.
- FIFO read: only in START/STREAM, exactly one read per cycle. Memory output is registered, so data_o is valid the cycle after the read issues.
- FSM states:
  - WAIT_FILL: all outputs low (except sticky flags and the counter). When count ≥ FRAME_LEN, issue read of sample 0 → START.
  - START: a transient state lasting 1 cycle. On the cycle after the WAIT_FILL→START transition:
    - start_o=1, data_vaild_o=1, data_o=sample 0;
    - read of sample 1 issued;
    - → STREAM.
  - STREAM: data_vaild_o=1 for samples 1..FRAME_LEN-1, one per cycle with no gaps, using an internal sample counter.
    - data_vaild_o is high for exactly FRAME_LEN consecutive cycles per frame.
    - No read is issued past sample FRAME_LEN-1.
    - After the last sample → WAIT_DONE.
  - WAIT_DONE: data_vaild_o=0; the timeout counter increments each cycle.
    - On done_i=1: frame_cnt_o++ and → WAIT_FILL.
    - Else on counter reaching TIMEOUT: timeout_o=1, frame_cnt_o++ and → WAIT_FILL.
    - If done_i and timeout coincide, done_i wins and timeout_o is not set.
- done_i outside WAIT_DONE is ignored.
- Back-to-back frames: if ≥ FRAME_LEN samples are already buffered when WAIT_DONE exits, the next start_o occurs 2 cycles after the done_i cycle (1 cycle in WAIT_FILL, then START).
- Input writes continue in every state, including during STREAM and WAIT_DONE.
- Latency: from the cycle the FRAME_LEN-th sample is written (state WAIT_FILL) to start_o is 2 cycles.
- busy_o is combinational from state.

Test Plan (FRAME_LEN=8, FIFO_DEPTH=16, TIMEOUT=20):
- Basic frame: reset, write 0x00..0x07 on consecutive cycles → start_o once, 2 cycles after 0x07 written; data_o=0x00..0x07 on 8 consecutive data_vaild_o cycles; busy_o high; data_vaild_o=0 afterwards.
- Verdict handshake: write 16 samples 0x10..0x1F, pulse done_i 5 cycles after the first frame ends → second frame 0x18..0x1F starts 2 cycles after done_i; frame_cnt_o=1, then 2 after the second done_i.
- Overflow: no done_i; write 30 samples continuously → overflow_o=1 from the first dropped write and stays 1. The 8 samples drained by the first frame make room for 8 extra writes; the drop pattern must match a reference model.
- Timeout: one frame, no done_i → timeout_o=1 and frame_cnt_o=1 exactly 20 cycles after WAIT_DONE entry. Repeat with done_i on the 20th cycle → timeout_o stays 0.
- Reset mid-STREAM: assert rst_i after sample 3 is output → next cycle all outputs 0, count 0. Write 8 new samples 0xA0..0xA7 → frame carries exactly 0xA0..0xA7.
- Spurious done_i: pulse done_i in WAIT_FILL and during STREAM → no state change, frame_cnt_o unchanged, frame still completes with 8 samples.
